// File: rtl/data_mem_seq_pkg.sv
// mem_seq_pkg: shared state encoding and default RAM base for the data-memory sequencer.
package mem_seq_pkg;
    typedef enum logic [1:0] {IDLE, LD_RESP, SB_WR} state_t;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0001_0000;
endpackage

// File: rtl/data_mem_seq_if.sv
// data_mem_seq_if: pipeline request/response and synchronous RAM port bundle.
interface data_mem_seq_if #(parameter int DATA_WIDTH = 32, parameter int MEM_AW = 15);
    logic                  req_valid;
    logic                  req_we;
    logic                  req_st_byte;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  stall;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  err;
    logic [MEM_AW-1:0]     mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_st_byte, req_addr, req_wdata, mem_rdata,
        output stall, rd_valid, rd_data, err, mem_addr, mem_re, mem_we, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_st_byte, req_addr, req_wdata, mem_rdata,
        input  stall, rd_valid, rd_data, err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/data_mem_seq_byte_lane_merge.sv
// byte_lane_merge: replaces one byte lane of a word, leaving the other lanes intact.
module byte_lane_merge #(parameter int DATA_WIDTH = 32) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            lane,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] merged
);
    always_comb begin
        merged = word;
        merged[8*lane +: 8] = byte_in;
    end
endmodule

// File: rtl/data_mem_seq.sv
// data_mem_seq: memory-stage sequencer for LW/SW/SB over a synchronous single-port RAM;
// SB is a read-modify-write, so it and LW each hold the pipeline for one cycle.
module data_mem_seq
    import mem_seq_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_AW     = 15,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input logic           clk,
    input logic           rst_n,
    data_mem_seq_if.slave bus
);
    state_t                state, next;
    logic [DATA_WIDTH-1:0] offset, widx_full, rd_data_q, merged;
    logic [MEM_AW-1:0]     widx, idx_q;
    logic [1:0]            lane_q;
    logic [7:0]            byte_q;
    logic                  is_sb, is_sw, bad;

    assign offset    = bus.req_addr - BASE_ADDR;
    assign widx_full = offset >> 2;
    assign widx      = widx_full[MEM_AW-1:0];
    assign is_sb     = bus.req_we & bus.req_st_byte;
    assign is_sw     = bus.req_we & ~bus.req_st_byte;
    assign bad       = (bus.req_addr < BASE_ADDR) | ((widx_full >> MEM_AW) != '0)
                     | (~is_sb & (bus.req_addr[1:0] != 2'b00));

    byte_lane_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .word(bus.mem_rdata), .lane(lane_q), .byte_in(byte_q), .merged(merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx_q     <= '0;
            lane_q    <= '0;
            byte_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state <= next;
            if (state == IDLE) begin
                idx_q  <= widx;
                lane_q <= bus.req_addr[1:0];
                byte_q <= bus.req_wdata[7:0];
            end
            if (state == LD_RESP) rd_data_q <= bus.mem_rdata;
        end
    end

    // Outputs are gated by rst_n so the strobes drop the moment reset asserts.
    always_comb begin
        next          = state;
        bus.stall     = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.err       = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = widx;
        bus.mem_wdata = bus.req_wdata;
        bus.rd_data   = (state == LD_RESP) ? bus.mem_rdata : rd_data_q;
        if (rst_n) begin
            if (state == IDLE && bus.req_valid) begin
                if (bad) bus.err = 1'b1;
                else if (is_sw) bus.mem_we = 1'b1;
                else begin
                    bus.mem_re = 1'b1;
                    bus.stall  = 1'b1;
                    next       = is_sb ? SB_WR : LD_RESP;
                end
            end else if (state == LD_RESP) begin
                bus.rd_valid = 1'b1;
                next         = IDLE;
            end else if (state == SB_WR) begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = idx_q;
                bus.mem_wdata = merged;
                next          = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_seq.sv
// tb_data_mem_seq: directed requests push expected RAM writes, loads and errors into a
// scoreboard; a negedge monitor pops and compares whenever the DUT raises an event.
module tb_data_mem_seq;
    localparam logic [2:0] K_W = 3'b001, K_R = 3'b010, K_E = 3'b100;
    typedef struct {
        logic [2:0]  kind;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] ram [int];
    exp_t        sb_q [$];

    data_mem_seq_if bus ();
    data_mem_seq u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= ram.exists(int'(bus.mem_addr)) ? ram[int'(bus.mem_addr)] : 32'h0;
        if (bus.mem_we) ram[int'(bus.mem_addr)] = bus.mem_wdata;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) last_rd = '0;
        check("re_we_exclusive", {31'b0, bus.mem_re & bus.mem_we}, 32'h0);
        if (bus.mem_we || bus.rd_valid || bus.err) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: we=%b rd_valid=%b err=%b addr=%h", bus.mem_we, bus.rd_valid, bus.err, bus.mem_addr);
            end else begin
                e = sb_q.pop_front();
                check("event_kind", {29'b0, bus.err, bus.rd_valid, bus.mem_we}, {29'b0, e.kind});
                if (e.kind == K_W) begin
                    check("write_index", {17'b0, bus.mem_addr}, e.a);
                    check("write_data", bus.mem_wdata, e.d);
                end else if (e.kind == K_R) begin
                    check("load_data", bus.rd_data, e.d);
                    last_rd = e.d;
                end else check("err_no_strobes", {29'b0, bus.mem_re, bus.mem_we, bus.stall}, 32'h0);
            end
        end
        if (!bus.rd_valid) check("rd_data_hold", bus.rd_data, last_rd);
    end

    task automatic do_req(input logic we, input logic sb, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_stall);
        int cnt = 0;
        bus.req_valid   = 1'b1;
        bus.req_we      = we;
        bus.req_st_byte = sb;
        bus.req_addr    = addr;
        bus.req_wdata   = wdata;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
            cnt++;
            @(posedge clk);
            #1;
        end
        check("stall_cycles", cnt, exp_stall);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] kind, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid   = 1'b1;
        bus.req_we      = 1'b0;
        bus.req_st_byte = 1'b0;
        bus.req_addr    = 32'h0001_0004;
        bus.req_wdata   = 32'h0;
        bus.mem_rdata   = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_stall", {31'b0, bus.stall}, 32'h0);
        check("reset_mem_re", {31'b0, bus.mem_re}, 32'h0);
        check("reset_outputs", {28'b0, bus.rd_valid, bus.err, bus.mem_we, bus.mem_re}, 32'h0);
        check("reset_rd_data", bus.rd_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;

        push(K_W, 32'd1, 32'hDEAD_BEEF);
        do_req(1, 0, 32'h0001_0004, 32'hDEAD_BEEF, 0);
        push(K_R, 32'd0, 32'hDEAD_BEEF);
        do_req(0, 0, 32'h0001_0004, 32'h0, 1);
        push(K_W, 32'd1, 32'hDE55_BEEF);
        do_req(1, 1, 32'h0001_0006, 32'h0000_0055, 1);
        push(K_R, 32'd0, 32'hDE55_BEEF);
        do_req(0, 0, 32'h0001_0004, 32'h0, 1);

        push(K_E, 32'd0, 32'd0);
        do_req(0, 0, 32'h0001_0002, 32'h0, 0);
        push(K_E, 32'd0, 32'd0);
        do_req(1, 0, 32'h0000_FFFC, 32'h1234_5678, 0);
        push(K_E, 32'd0, 32'd0);
        do_req(0, 0, 32'h0003_0000, 32'h0, 0);
        push(K_E, 32'd0, 32'd0);
        do_req(1, 0, 32'h0001_0001, 32'h0, 0);

        push(K_W, 32'd32767, 32'h1234_5678);
        do_req(1, 0, 32'h0002_FFFC, 32'h1234_5678, 0);
        push(K_R, 32'd0, 32'h1234_5678);
        do_req(0, 0, 32'h0002_FFFC, 32'h0, 1);

        push(K_W, 32'd0, 32'hAABB_CCDD);
        do_req(1, 0, 32'h0001_0000, 32'hAABB_CCDD, 0);
        push(K_W, 32'd0, 32'hAABB_CC11);
        do_req(1, 1, 32'h0001_0000, 32'h0000_0011, 1);
        push(K_W, 32'd0, 32'h22BB_CC11);
        do_req(1, 1, 32'h0001_0003, 32'h0000_0022, 1);
        push(K_R, 32'd0, 32'h22BB_CC11);
        do_req(0, 0, 32'h0001_0000, 32'h0, 1);
        push(K_W, 32'd1, 32'hDE55_77EF);
        do_req(1, 1, 32'h0001_0005, 32'hFFFF_FF77, 1);

        bus.req_valid   = 1'b1;
        bus.req_we      = 1'b1;
        bus.req_st_byte = 1'b1;
        bus.req_addr    = 32'h0001_0004;
        bus.req_wdata   = 32'h0000_0099;
        @(negedge clk);
        check("sb_read_stall", {30'b0, bus.stall, bus.mem_re}, 32'h3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_no_write", {31'b0, bus.mem_we}, 32'h0);
        check("abort_outputs", {28'b0, bus.stall, bus.rd_valid, bus.err, bus.mem_re}, 32'h0);
        check("abort_rd_data", bus.rd_data, 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n         = 1'b1;
        push(K_R, 32'd0, 32'hDE55_77EF);
        do_req(0, 0, 32'h0001_0004, 32'h0, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_seq.md
DATA_MEM_SEQ -- requirements
Module: data_mem_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the data path and request address.
REQ-002 Parameter MEM_AW, default 15: word-index width of the RAM port (32K words).
REQ-003 Parameter BASE_ADDR, default 32'h0001_0000: byte address of RAM word 0.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  memory-stage access request present.
REQ-007 req_we  input  1  1 means store, 0 means load.
REQ-008 req_st_byte  input  1  for stores: 0 means word (SW), 1 means byte (SB).
REQ-009 req_addr  input  DATA_WIDTH  byte address.
REQ-010 req_wdata  input  DATA_WIDTH  store data; SB uses bits [7:0].
REQ-011 stall  output  1  pipeline hold; the request stays stable while stall=1.
REQ-012 rd_valid  output  1  one-cycle pulse; rd_data holds the loaded word.
REQ-013 rd_data  output  DATA_WIDTH  raw aligned word; the extend stage is downstream.
REQ-014 err  output  1  one-cycle pulse on a misaligned or out-of-range access.
REQ-015 mem_addr  output  MEM_AW  RAM word index.
REQ-016 mem_re, mem_we  output  1 each  RAM read enable and write enable.
REQ-017 mem_wdata  output  DATA_WIDTH  RAM write data.
REQ-018 mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after mem_re (synchronous RAM).

Function
REQ-019 The FSM SHALL have three states: IDLE, LD_RESP, SB_WR.
REQ-020 Word index SHALL be (req_addr - BASE_ADDR) >> 2, truncated to MEM_AW.
REQ-021 A request is out of range if req_addr < BASE_ADDR or the word index is >= 2**MEM_AW.
REQ-022 Access checks in IDLE with req_valid=1:
- LW and SW with req_addr[1:0] != 0 are misaligned.
- SB is never misaligned.
- On misaligned or out-of-range: err=1 that cycle, no mem_re/mem_we, stall=0, state stays IDLE.
REQ-023 IDLE, valid SW: mem_we=1, mem_wdata=req_wdata, stall=0, state stays IDLE (latency 1).
REQ-024 IDLE, valid load: mem_re=1, stall=1, next state LD_RESP.
REQ-025 LD_RESP: rd_valid=1, rd_data=mem_rdata, stall=0, next state IDLE.
REQ-026 IDLE, valid SB: mem_re=1, stall=1; latch word index, lane=addr[1:0] and wdata[7:0]; next state SB_WR.
REQ-027 SB_WR: mem_we=1 at the latched index, stall=0, next state IDLE.
REQ-028 SB_WR merge: mem_wdata = mem_rdata with byte lane (8*lane+7 : 8*lane) replaced by the latched byte; all other bytes unchanged.
REQ-029 In LD_RESP and SB_WR, request inputs SHALL be ignored; this is the same held request.
REQ-030 Request decode occurs only in IDLE, so a new request is accepted the cycle after LD_RESP or SB_WR.
REQ-031 rd_data SHALL hold its last loaded value when rd_valid=0.
REQ-032 mem_re and mem_we SHALL never both be 1 in the same cycle.
REQ-033 With req_valid=0 in IDLE: all strobes 0 and stall=0.

Reset
REQ-034 rst_n=0 SHALL force IDLE immediately, with stall, rd_valid, err, mem_re, mem_we = 0 and rd_data = 0.
REQ-035 Reset during LD_RESP or SB_WR SHALL abort the operation: no write is issued, and a pending SB is discarded.
REQ-036 The first request is accepted on the first rising edge with rst_n=1.

Structure
REQ-037 Package mem_seq_pkg SHALL hold the state enum and the default BASE_ADDR constant.
REQ-038 Sub-module byte_lane_merge (combinational) SHALL hold the lane replacement of REQ-028.
REQ-039 Only registers: state, latched word index, latched lane, latched byte, rd_data.

Verification
REQ-040 Reset, then SW addr 0x10004 data 0xDEADBEEF -> mem_we=1, index 1, stall=0, single cycle.
REQ-041 LW 0x10004 with mem_rdata=0xDEADBEEF -> stall for 1 cycle, then rd_valid=1, rd_data=0xDEADBEEF.
REQ-042 SB addr 0x10006 data 0x55, RAM word 0xDEADBEEF -> read cycle, then write of 0xDE55BEEF, stall high 1 cycle.
REQ-043 LW 0x10002, then SW 0x0000FFFC -> err pulse each, no RAM strobes, stall=0.
REQ-044 SB accepted, rst_n low in SB_WR -> no mem_we; outputs zero; IDLE.
REQ-045 Back-to-back SB 0x10000/0x11 then SB 0x10003/0x22 on word 0 -> final word has byte0=0x11 and byte3=0x22.
